// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: stall bit positions, stall vectors, FSM states.
// Priority resolution lives here so every consumer agrees on the bubble boundary.
package pipe_ctrl_pkg;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int STALL_PC     = 0;
  localparam int STALL_IF_ID  = 1;
  localparam int STALL_ID_EX  = 2;
  localparam int STALL_EX_MEM = 3;
  localparam int STALL_MEM_WB = 4;
  localparam int STALL_WB     = 5;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic {
    CTRL_IDLE    = 1'b0,
    CTRL_PENDING = 1'b1
  } ctrl_state_e;

  // Each vector is a contiguous run of ones from bit 0, so the first running
  // stage after the run always receives a bubble.
  function automatic logic [5:0] stall_resolve(input logic req_if, input logic req_id,
                                               input logic req_ex, input logic req_mem);
    logic [5:0] v;
    v = STALL_NONE;
    if (req_mem)     v = STALL_MEM;
    else if (req_ex) v = STALL_EX;
    else if (req_id) v = STALL_ID;
    else if (req_if) v = STALL_IF;
    return v;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
// One cycle from inc_i to updated cnt_o.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clear_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: priority stall vector, flush, and EX redirects held while the PC is frozen.
// Stall/flush/redirect are combinational (zero latency); counters update at the next edge.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          CNT_W    = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic             branch_flag_i,
  input  logic [31:0]      branch_target_i,
  output logic [5:0]       stall,
  output logic             flush_o,
  output logic             redirect_valid_o,
  output logic [31:0]      redirect_pc_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  ctrl_state_e state_q, state_d;
  logic [31:0] target_q, target_d;
  logic        branch_acc;

  always_comb begin
    state_d          = state_q;
    target_d         = target_q;
    stall            = stall_resolve(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
    flush_o          = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = branch_target_i;
    branch_acc       = 1'b0;

    if (rst) begin
      stall         = STALL_NONE;
      redirect_pc_o = RESET_PC;
      state_d       = CTRL_IDLE;
      target_d      = RESET_PC;
    end else begin
      case (state_q)
        CTRL_IDLE: begin
          // A stalled EX re-presents its branch, so only take it when EX advances.
          if (branch_flag_i && (stall[STALL_EX_MEM] == NO_STOP)) begin
            branch_acc = 1'b1;
            flush_o    = 1'b1;
            if (stall[STALL_PC] == NO_STOP) begin
              redirect_valid_o = 1'b1;
            end else begin
              target_d = branch_target_i;
              state_d  = CTRL_PENDING;
            end
          end
        end
        CTRL_PENDING: begin
          flush_o       = 1'b1;
          redirect_pc_o = target_q;
          if (stall[STALL_PC] == NO_STOP) begin
            redirect_valid_o = 1'b1;
            state_d          = CTRL_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CTRL_IDLE;
      target_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .clear_i (rst),
    .inc_i   (stall[STALL_PC] == STOP),
    .cnt_o   (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .clear_i (rst),
    .inc_i   (branch_acc),
    .cnt_o   (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a scoreboard of expected outputs per cycle.
// Narrow counters so saturation is reachable in a few dozen cycles.
module tb_pipe_ctrl;

  localparam int          CNT_W    = 5;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam logic [3:0] R_NONE = 4'b0000;
  localparam logic [3:0] R_IF   = 4'b0001;
  localparam logic [3:0] R_ID   = 4'b0010;
  localparam logic [3:0] R_EX   = 4'b0100;
  localparam logic [3:0] R_MEM  = 4'b1000;
  localparam logic [3:0] R_ALL  = 4'b1111;

  logic             clk;
  logic             rst;
  logic             stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic             branch_flag_i;
  logic [31:0]      branch_target_i;
  logic [5:0]       stall;
  logic             flush_o;
  logic             redirect_valid_o;
  logic [31:0]      redirect_pc_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  typedef struct {
    logic [5:0]       stall;
    logic             flush;
    logic             rv;
    logic [31:0]      pc;
    logic [CNT_W-1:0] scnt;
    logic [CNT_W-1:0] fcnt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] scnt_m = '0;
  logic [CNT_W-1:0] fcnt_m = '0;

  pipe_ctrl #(.CNT_W(CNT_W), .RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_if      (stallreq_if),
    .stallreq_id      (stallreq_id),
    .stallreq_ex      (stallreq_ex),
    .stallreq_mem     (stallreq_mem),
    .branch_flag_i    (branch_flag_i),
    .branch_target_i  (branch_target_i),
    .stall            (stall),
    .flush_o          (flush_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .stall_cnt_o      (stall_cnt_o),
    .flush_cnt_o      (flush_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, queue the expectation, compare at the falling edge,
  // then advance the counter model across the rising edge.
  task automatic step(input string tag, input logic r, input logic [3:0] req,
                      input logic bf, input logic [31:0] bt,
                      input logic [5:0] e_stall, input logic e_fl, input logic e_rv,
                      input logic [31:0] e_pc, input logic e_acc);
    exp_t e, got;
    rst             = r;
    stallreq_mem    = req[3];
    stallreq_ex     = req[2];
    stallreq_id     = req[1];
    stallreq_if     = req[0];
    branch_flag_i   = bf;
    branch_target_i = bt;
    e.stall = e_stall; e.flush = e_fl; e.rv = e_rv; e.pc = e_pc;
    e.scnt  = scnt_m;  e.fcnt  = fcnt_m;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    check({tag, ".stall"}, 32'(stall), 32'(got.stall));
    check({tag, ".flush"}, 32'(flush_o), 32'(got.flush));
    check({tag, ".rv"},    32'(redirect_valid_o), 32'(got.rv));
    check({tag, ".pc"},    redirect_pc_o, got.pc);
    check({tag, ".scnt"},  32'(stall_cnt_o), 32'(got.scnt));
    check({tag, ".fcnt"},  32'(flush_cnt_o), 32'(got.fcnt));
    if (r) begin
      scnt_m = '0;
      fcnt_m = '0;
    end else begin
      if (e_stall[0] && scnt_m != CNT_MAX) scnt_m = scnt_m + 1'b1;
      if (e_acc && fcnt_m != CNT_MAX)      fcnt_m = fcnt_m + 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    stallreq_if = 1'b0; stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0;
    branch_flag_i = 1'b0; branch_target_i = '0;
    @(posedge clk);
    #1;

    // Reset with every input active: outputs forced quiet.
    for (int i = 0; i < 3; i++)
      step("rst", 1'b1, R_ALL, 1'b1, 32'hAA, 6'b000000, 1'b0, 1'b0, RESET_PC, 1'b0);
    step("idle", 1'b0, R_NONE, 1'b0, 32'h0, 6'b000000, 1'b0, 1'b0, 32'h0, 1'b0);

    // Priority encoding.
    step("mem", 1'b0, R_MEM, 1'b0, 32'h0, 6'b011111, 1'b0, 1'b0, 32'h0, 1'b0);
    step("ex",  1'b0, R_EX,  1'b0, 32'h0, 6'b001111, 1'b0, 1'b0, 32'h0, 1'b0);
    step("id",  1'b0, R_ID,  1'b0, 32'h0, 6'b000111, 1'b0, 1'b0, 32'h0, 1'b0);
    step("if",  1'b0, R_IF,  1'b0, 32'h0, 6'b000011, 1'b0, 1'b0, 32'h0, 1'b0);
    step("all", 1'b0, R_ALL, 1'b0, 32'h0, 6'b011111, 1'b0, 1'b0, 32'h0, 1'b0);

    // Zero-latency redirect.
    step("br100", 1'b0, R_NONE, 1'b1, 32'h100, 6'b000000, 1'b1, 1'b1, 32'h100, 1'b1);
    step("br100n", 1'b0, R_NONE, 1'b0, 32'h0, 6'b000000, 1'b0, 1'b0, 32'h0, 1'b0);

    // Redirect held while IF stalls; a second branch is ignored.
    step("p200a", 1'b0, R_IF, 1'b1, 32'h200, 6'b000011, 1'b1, 1'b0, 32'h200, 1'b1);
    step("p200b", 1'b0, R_IF, 1'b1, 32'h300, 6'b000011, 1'b1, 1'b0, 32'h200, 1'b0);
    step("p200c", 1'b0, R_IF, 1'b0, 32'h300, 6'b000011, 1'b1, 1'b0, 32'h200, 1'b0);
    step("p200d", 1'b0, R_IF, 1'b0, 32'h300, 6'b000011, 1'b1, 1'b0, 32'h200, 1'b0);
    step("p200r", 1'b0, R_NONE, 1'b1, 32'h500, 6'b000000, 1'b1, 1'b1, 32'h200, 1'b0);
    step("p200i", 1'b0, R_NONE, 1'b0, 32'h0, 6'b000000, 1'b0, 1'b0, 32'h0, 1'b0);

    // Branch blocked while MEM stalls EX, accepted once it drops.
    step("m600a", 1'b0, R_MEM, 1'b1, 32'h600, 6'b011111, 1'b0, 1'b0, 32'h600, 1'b0);
    step("m600b", 1'b0, R_MEM, 1'b1, 32'h600, 6'b011111, 1'b0, 1'b0, 32'h600, 1'b0);
    step("m600c", 1'b0, R_NONE, 1'b1, 32'h600, 6'b000000, 1'b1, 1'b1, 32'h600, 1'b1);

    // Reset during PENDING discards the held target.
    step("p400a", 1'b0, R_IF, 1'b1, 32'h400, 6'b000011, 1'b1, 1'b0, 32'h400, 1'b1);
    step("p400r", 1'b1, R_IF, 1'b0, 32'h0, 6'b000000, 1'b0, 1'b0, RESET_PC, 1'b0);
    step("p400x", 1'b0, R_NONE, 1'b0, 32'h0, 6'b000000, 1'b0, 1'b0, 32'h0, 1'b0);
    step("p400y", 1'b0, R_NONE, 1'b0, 32'h0, 6'b000000, 1'b0, 1'b0, 32'h0, 1'b0);

    // Stall counter saturates.
    for (int i = 0; i < 34; i++)
      step("sat", 1'b0, R_IF, 1'b0, 32'h0, 6'b000011, 1'b0, 1'b0, 32'h0, 1'b0);
    step("satend", 1'b0, R_NONE, 1'b0, 32'h0, 6'b000000, 1'b0, 1'b0, 32'h0, 1'b0);
    check("sat_hold", 32'(stall_cnt_o), 32'(CNT_MAX));
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
